cla_seq_adder_ctrl: RTL and testbench



---
 rtl/cla_seq_adder_ctrl_pkg.sv | 13 +
 rtl/carry_look_ahead4bit.sv | 28 ++
 rtl/cla_seq_adder_ctrl.sv | 150 +++++++++++++++
 tb/tb_cla_seq_adder_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/cla_seq_adder_ctrl_pkg.sv
// Shared definitions for the sequential carry-look-ahead adder:
// controller state encodings and the nibble width of the shared slice.
package cla_seq_adder_ctrl_pkg;

    localparam int unsigned NIBBLE_W = 4;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } cla_state_e;

endpackage

// File: rtl/carry_look_ahead4bit.sv
// 4-bit carry-look-ahead adder slice; all carries are computed in parallel
// from the generate/propagate terms.
module carry_look_ahead4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [3:0] p;
    logic [3:0] g;
    logic [4:0] c;

    always_comb begin
        p    = a ^ b;
        g    = a & b;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & cin);
        sum  = p ^ c[3:0];
        cout = c[4];
    end

endmodule

// File: rtl/cla_seq_adder_ctrl.sv
// WIDTH-bit adder that reuses one 4-bit CLA slice, one nibble per clock, LSB first.
// Define CLA_SEQ_SUB_EN to add a 'sub' input that turns the operation into a - b.
module cla_seq_adder_ctrl
    import cla_seq_adder_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef CLA_SEQ_SUB_EN
    input  logic             sub,
`endif
    output logic             result_valid,
    input  logic             result_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int unsigned NIBBLES = WIDTH / NIBBLE_W;
    localparam int unsigned KW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [KW-1:0] KLast = KW'(NIBBLES - 1);

    cla_state_e       state_q, state_d;
    logic [KW-1:0]    k_q, k_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             start_ready_q, start_ready_d;
    logic             result_valid_q, result_valid_d;
    logic             busy_q, busy_d;

    logic [NIBBLE_W-1:0] sl_a;
    logic [NIBBLE_W-1:0] sl_b;
    logic [NIBBLE_W-1:0] sl_sum;
    logic                sl_cout;

    always_comb begin
        sl_a = a_q[k_q*NIBBLE_W +: NIBBLE_W];
        sl_b = b_q[k_q*NIBBLE_W +: NIBBLE_W];
    end

    carry_look_ahead4bit u_slice (
        .a    (sl_a),
        .b    (sl_b),
        .cin  (carry_q),
        .sum  (sl_sum),
        .cout (sl_cout)
    );

    always_comb begin
        state_d        = state_q;
        k_d            = k_q;
        a_d            = a_q;
        b_d            = b_q;
        sum_d          = sum_q;
        carry_d        = carry_q;
        cout_d         = cout_q;
        start_ready_d  = start_ready_q;
        result_valid_d = result_valid_q;
        busy_d         = busy_q;
        unique case (state_q)
            StIdle: begin
                if (start_valid) begin
                    a_d           = a;
`ifdef CLA_SEQ_SUB_EN
                    // Two's-complement subtract: invert b and force the carry-in.
                    b_d           = sub ? ~b : b;
                    carry_d       = sub ? 1'b1 : cin;
`else
                    b_d           = b;
                    carry_d       = cin;
`endif
                    k_d           = '0;
                    sum_d         = '0;
                    state_d       = StRun;
                    start_ready_d = 1'b0;
                    busy_d        = 1'b1;
                end
            end
            StRun: begin
                sum_d[k_q*NIBBLE_W +: NIBBLE_W] = sl_sum;
                carry_d                         = sl_cout;
                if (k_q == KLast) begin
                    cout_d         = sl_cout;
                    k_d            = '0;
                    state_d        = StDone;
                    result_valid_d = 1'b1;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            StDone: begin
                if (result_ready) begin
                    state_d        = StIdle;
                    result_valid_d = 1'b0;
                    busy_d         = 1'b0;
                    start_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d        = StIdle;
                k_d            = '0;
                result_valid_d = 1'b0;
                busy_d         = 1'b0;
                start_ready_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= StIdle;
            k_q            <= '0;
            a_q            <= '0;
            b_q            <= '0;
            sum_q          <= '0;
            carry_q        <= 1'b0;
            cout_q         <= 1'b0;
            start_ready_q  <= 1'b1;
            result_valid_q <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            k_q            <= k_d;
            a_q            <= a_d;
            b_q            <= b_d;
            sum_q          <= sum_d;
            carry_q        <= carry_d;
            cout_q         <= cout_d;
            start_ready_q  <= start_ready_d;
            result_valid_q <= result_valid_d;
            busy_q         <= busy_d;
        end
    end

    assign start_ready  = start_ready_q;
    assign result_valid = result_valid_q;
    assign busy         = busy_q;
    assign sum          = sum_q;
    assign cout         = cout_q;

endmodule

// File: tb/tb_cla_seq_adder_ctrl.sv
// Directed and randomised checks of the sequential CLA adder at WIDTH=16;
// define CLA_SEQ_SUB_EN to also exercise the subtract path.
module tb_cla_seq_adder_ctrl;

    logic        clk;
    logic        rst;
    logic        start_valid;
    logic        start_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
`ifdef CLA_SEQ_SUB_EN
    logic        sub;
`endif
    logic        result_valid;
    logic        result_ready;
    logic [15:0] sum;
    logic        cout;
    logic        busy;

    int n_total = 0;
    int n_bad   = 0;

    cla_seq_adder_ctrl #(
        .WIDTH (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start_valid  (start_valid),
        .start_ready  (start_ready),
        .a            (a),
        .b            (b),
        .cin          (cin),
`ifdef CLA_SEQ_SUB_EN
        .sub          (sub),
`endif
        .result_valid (result_valid),
        .result_ready (result_ready),
        .sum          (sum),
        .cout         (cout),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Accept one op, check latency and result, optionally hold backpressure, then retire.
    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_, input logic tc,
                          input logic tsub, input logic [15:0] es, input logic ec,
                          input int hold);
        int n;
        @(negedge clk);
        start_valid = 1'b1;
        a = ta;
        b = tb_;
        cin = tc;
`ifdef CLA_SEQ_SUB_EN
        sub = tsub;
`else
        if (tsub) check_eq("sub_unsupported", 32'(tsub), 32'd0);
`endif
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        check_eq("busy_after_accept", 32'(busy), 32'd1);
        check_eq("start_ready_after_accept", 32'(start_ready), 32'd0);
        n = 0;
        while (!result_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq("latency", 32'(n), 32'd4);
        check_eq("sum", 32'(sum), 32'(es));
        check_eq("cout", 32'(cout), 32'(ec));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            // A start request under backpressure must be ignored.
            start_valid = (i == 3);
            a = 16'hAAAA;
            b = 16'h5555;
            check_eq("hold_valid", 32'(result_valid), 32'd1);
            check_eq("hold_sum", 32'(sum), 32'(es));
            check_eq("hold_cout", 32'(cout), 32'(ec));
            check_eq("hold_start_ready", 32'(start_ready), 32'd0);
        end
        @(negedge clk);
        start_valid  = 1'b0;
        result_ready = 1'b1;
        @(posedge clk);
        #1;
        result_ready = 1'b0;
        check_eq("retired_valid", 32'(result_valid), 32'd0);
        check_eq("retired_start_ready", 32'(start_ready), 32'd1);
        check_eq("retired_busy", 32'(busy), 32'd0);
    endtask

    task automatic rand_op();
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rc;
        logic [16:0] gold;
        logic        seen;
        logic        done;
        int          n;
        ra   = 16'($urandom);
        rb   = 16'($urandom);
        rc   = 1'($urandom_range(0, 1));
        gold = {1'b0, ra} + {1'b0, rb} + {16'd0, rc};
        @(negedge clk);
        start_valid = 1'b1;
        a = ra;
        b = rb;
        cin = rc;
`ifdef CLA_SEQ_SUB_EN
        sub = 1'b0;
`endif
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        seen = 1'b0;
        done = 1'b0;
        n = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            result_ready = 1'($urandom_range(0, 1));
            if (result_valid && !seen) begin
                seen = 1'b1;
                check_eq("rand_result", 32'({cout, sum}), 32'(gold));
            end
            @(posedge clk);
            if (seen && result_ready) done = 1'b1;
            n++;
        end
        @(negedge clk);
        result_ready = 1'b0;
        if (!done) check_eq("rand_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int n;
        rst          = 1'b1;
        start_valid  = 1'b0;
        result_ready = 1'b0;
        a            = '0;
        b            = '0;
        cin          = 1'b0;
`ifdef CLA_SEQ_SUB_EN
        sub          = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_start_ready", 32'(start_ready), 32'd1);
        check_eq("rst_result_valid", 32'(result_valid), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_sum", 32'(sum), 32'd0);
        check_eq("rst_cout", 32'(cout), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op(16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 0);
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 0);
        run_op(16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 0);
        run_op(16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 10);
        run_op(16'h8421, 16'h7BDE, 1'b1, 1'b0, 16'h0000, 1'b1, 0);

        // Asynchronous reset in the middle of a run.
        @(negedge clk);
        start_valid = 1'b1;
        a = 16'hFFFF;
        b = 16'hFFFF;
        cin = 1'b1;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_eq("midrun_rst_start_ready", 32'(start_ready), 32'd1);
        check_eq("midrun_rst_busy", 32'(busy), 32'd0);
        check_eq("midrun_rst_valid", 32'(result_valid), 32'd0);
        check_eq("midrun_rst_sum", 32'(sum), 32'd0);
        check_eq("midrun_rst_cout", 32'(cout), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (result_valid) n++;
        end
        check_eq("no_valid_after_rst", 32'(n), 32'd0);
        run_op(16'h0003, 16'h0004, 1'b0, 1'b0, 16'h0007, 1'b0, 0);

`ifdef CLA_SEQ_SUB_EN
        run_op(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 0);
        run_op(16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1, 0);
`endif

        for (int i = 0; i < 1000; i++) rand_op();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
